// File: rtl/rain_seq_pkg.sv
// Shared types and sizing for the glyph-rain frame sequencer.
package rain_seq_pkg;

   typedef enum logic [1:0] {
      INTRO = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } seq_state_t;

   localparam int unsigned FRAME_W_DEF = 10;
   localparam int unsigned PAL_W       = 2;
   localparam int unsigned DEB_CNT_W   = 4;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchronizer -> frame-rate debounce -> single-cycle press pulse.
module btn_debounce
   import rain_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_en,
   input  logic btn_raw,
   output logic press
);

   logic                 sync1_q;
   logic                 sync2_q;
   logic                 level_q;
   logic [DEB_CNT_W-1:0] cnt_q;
   logic                 accept;

   // press is combinational so it lines up with the frame advance of the same vsync edge
   always_comb begin
      accept = sample_en && (sync2_q != level_q)
               && (cnt_q == DEB_CNT_W'(DEBOUNCE_TICKS - 1));
      press  = accept && sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         if (sample_en) begin
            if (sync2_q == level_q) begin
               cnt_q <= '0;
            end else if (accept) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + DEB_CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/rain_frame_sequencer.sv
// Frame counter, intro/run/pause sequencing and palette select for the glyph-rain datapath.
// Optional macro AUTO_PALETTE_EN: advance palette when the frame counter wraps in RUN.
module rain_frame_sequencer
   import rain_seq_pkg::*;
#(
   parameter int unsigned FRAME_W        = FRAME_W_DEF,
   parameter bit          VS_ACTIVE_LOW  = 1'b1,
   parameter int unsigned DEBOUNCE_TICKS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vsync_in,
   input  logic               pause_btn,
   input  logic               step_btn,
   input  logic               pal_btn,
   input  logic [1:0]         speed,
   output logic [FRAME_W-1:0] frame_o,
   output logic               intro_done_o,
   output logic [PAL_W-1:0]   pal_sel_o,
   output logic               frame_tick_o,
   output logic               paused_o
);

   logic               vs_q;
   logic               vs_edge;
   logic [1:0]         div_q;
   logic               adv;
   logic               pause_ev;
   logic               step_ev;
   logic               pal_ev;
   logic               frame_wrap;

   seq_state_t         state_q;
   logic [FRAME_W-1:0] frame_q;
   logic               intro_done_q;
   logic               tick_q;
   logic               paused_q;
   logic [PAL_W-1:0]   pal_q;
   logic [PAL_W-1:0]   pal_inc;
   logic [PAL_W-1:0]   pal_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vs_q <= 1'b0;
      else        vs_q <= vsync_in;
   end

   always_comb begin
      if (VS_ACTIVE_LOW) vs_edge = vs_q & ~vsync_in;
      else               vs_edge = ~vs_q & vsync_in;
      adv        = vs_edge && (div_q == speed);
      frame_wrap = &frame_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else if (vs_edge) begin
         div_q <= adv ? 2'd0 : div_q + 2'd1;
      end
   end

   btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_pause_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (vs_edge),
      .btn_raw   (pause_btn),
      .press     (pause_ev)
   );

   btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_step_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (vs_edge),
      .btn_raw   (step_btn),
      .press     (step_ev)
   );

   btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_pal_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (vs_edge),
      .btn_raw   (pal_btn),
      .press     (pal_ev)
   );

   // Palette increments from the button and the optional wrap are summed, so both may land together.
   always_comb begin
      pal_inc = '0;
      if (pal_ev) pal_inc = PAL_W'(1);
`ifdef AUTO_PALETTE_EN
      if ((state_q == RUN) && adv && frame_wrap) pal_inc = pal_inc + PAL_W'(1);
`endif
      pal_d = pal_q + pal_inc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= INTRO;
         frame_q      <= '0;
         intro_done_q <= 1'b0;
         tick_q       <= 1'b0;
         paused_q     <= 1'b0;
         pal_q        <= '0;
      end else begin
         tick_q <= 1'b0;
         pal_q  <= pal_d;
         case (state_q)
            INTRO: begin
               if (adv) begin
                  frame_q <= frame_q + FRAME_W'(1);
                  tick_q  <= 1'b1;
                  if (frame_wrap) begin
                     intro_done_q <= 1'b1;
                     state_q      <= RUN;
                  end
               end
            end
            RUN: begin
               if (adv) begin
                  frame_q <= frame_q + FRAME_W'(1);
                  tick_q  <= 1'b1;
               end
               if (pause_ev) begin
                  state_q  <= PAUSE;
                  paused_q <= 1'b1;
               end
            end
            PAUSE: begin
               if (pause_ev) begin
                  state_q  <= RUN;
                  paused_q <= 1'b0;
               end else if (step_ev) begin
                  frame_q <= frame_q + FRAME_W'(1);
                  tick_q  <= 1'b1;
               end
            end
            default: begin
               state_q  <= INTRO;
               paused_q <= 1'b0;
            end
         endcase
      end
   end

   assign frame_o      = frame_q;
   assign intro_done_o = intro_done_q;
   assign pal_sel_o    = pal_q;
   assign frame_tick_o = tick_q;
   assign paused_o     = paused_q;

endmodule

// File: tb/tb_rain_frame_sequencer.sv
// Scoreboard bench for rain_frame_sequencer: expected frame values queued per vsync, checked on each tick.
module tb_rain_frame_sequencer;

   logic       clk;
   logic       rst_n;
   logic       vsync_in;
   logic       pause_btn;
   logic       step_btn;
   logic       pal_btn;
   logic [1:0] speed;
   logic [9:0] frame_o;
   logic       intro_done_o;
   logic [1:0] pal_sel_o;
   logic       frame_tick_o;
   logic       paused_o;

   int         n_checks = 0;
   int         n_errors = 0;
   int         tick_cnt = 0;
   logic [9:0] model_frame = '0;
   logic [9:0] exp_q[$];
   logic [1:0] exp_pal;

`ifdef AUTO_PALETTE_EN
   localparam logic [1:0] AUTO_INC = 2'd1;
`else
   localparam logic [1:0] AUTO_INC = 2'd0;
`endif

   rain_frame_sequencer #(
      .FRAME_W        (10),
      .VS_ACTIVE_LOW  (1'b1),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .vsync_in     (vsync_in),
      .pause_btn    (pause_btn),
      .step_btn     (step_btn),
      .pal_btn      (pal_btn),
      .speed        (speed),
      .frame_o      (frame_o),
      .intro_done_o (intro_done_o),
      .pal_sel_o    (pal_sel_o),
      .frame_tick_o (frame_tick_o),
      .paused_o     (paused_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One active-low vsync pulse, two lines wide; exp_tick says whether a frame update must follow.
   task automatic vs_pulse(input bit exp_tick);
      repeat (3) @(negedge clk);
      if (exp_tick) begin
         model_frame = model_frame + 10'd1;
         exp_q.push_back(model_frame);
      end
      vsync_in = 1'b0;
      @(negedge clk);
      check("tick_lat", frame_tick_o, exp_tick);
      @(negedge clk);
      check("tick_width", frame_tick_o, 0);
      vsync_in = 1'b1;
      @(negedge clk);
      check("tick_rise", frame_tick_o, 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && frame_tick_o) begin
            tick_cnt++;
            if (exp_q.size() == 0) check("tick_unexp", 1, 0);
            else                   check("frame", frame_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      vsync_in  = 1'b1;
      pause_btn = 1'b0;
      step_btn  = 1'b0;
      pal_btn   = 1'b0;
      speed     = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_frame", frame_o, 0);
      check("rst_intro", intro_done_o, 0);
      check("rst_pal", pal_sel_o, 0);
      check("rst_tick", frame_tick_o, 0);
      check("rst_paused", paused_o, 0);
      rst_n = 1'b1;

      // Intro: 1024 edges, with a pause press in the middle that must be ignored.
      for (int i = 1; i <= 1024; i++) begin
         pause_btn = (i >= 10 && i <= 12);
         if (i == 1024) begin
            check("intro_pre_done", intro_done_o, 0);
            check("intro_pre_frame", frame_o, 1023);
         end
         vs_pulse(1'b1);
         if (i == 20) check("intro_pause_ign", paused_o, 0);
      end
      check("intro_done", intro_done_o, 1);
      check("intro_wrap", frame_o, 0);
      check("intro_ticks", tick_cnt, 1024);
      check("intro_pal", pal_sel_o, 0);

      // speed=2: one advance per three edges.
      speed = 2'd2;
      for (int i = 1; i <= 9; i++) vs_pulse(i % 3 == 0);
      check("speed2_frame", frame_o, 3);
      speed = 2'd0;

      // Pause held four edges: accepted on the third, fourth edge is frozen.
      pause_btn = 1'b1;
      vs_pulse(1'b1); vs_pulse(1'b1); vs_pulse(1'b1);
      check("paused_set", paused_o, 1);
      vs_pulse(1'b0);
      pause_btn = 1'b0;
      for (int i = 0; i < 23; i++) vs_pulse(1'b0);
      check("pause_frozen", frame_o, 6);
      check("pause_still", paused_o, 1);

      // Single step.
      step_btn = 1'b1;
      vs_pulse(1'b0); vs_pulse(1'b0); vs_pulse(1'b1);
      step_btn = 1'b0;
      for (int i = 0; i < 3; i++) vs_pulse(1'b0);
      check("step_frame", frame_o, 7);
      check("step_paused", paused_o, 1);

      // Pause and step accepted together: resume wins, no increment.
      pause_btn = 1'b1;
      step_btn  = 1'b1;
      vs_pulse(1'b0); vs_pulse(1'b0); vs_pulse(1'b0);
      check("both_resume", paused_o, 0);
      check("both_frame", frame_o, 7);
      pause_btn = 1'b0;
      step_btn  = 1'b0;
      for (int i = 0; i < 3; i++) vs_pulse(1'b1);
      check("run_again", frame_o, 10);

      // Palette: short glitch ignored, then four presses.
      pal_btn = 1'b1;
      vs_pulse(1'b1); vs_pulse(1'b1);
      pal_btn = 1'b0;
      for (int i = 0; i < 3; i++) vs_pulse(1'b1);
      check("pal_glitch", pal_sel_o, 0);
      exp_pal = 2'd0;
      for (int p = 0; p < 4; p++) begin
         pal_btn = 1'b1;
         for (int i = 0; i < 3; i++) vs_pulse(1'b1);
         exp_pal = exp_pal + 2'd1;
         check("pal_press", pal_sel_o, exp_pal);
         pal_btn = 1'b0;
         for (int i = 0; i < 3; i++) vs_pulse(1'b1);
         check("pal_release", pal_sel_o, exp_pal);
      end

      // RUN wrap without button.
      while (model_frame != 10'd1023) vs_pulse(1'b1);
      check("wrapA_pre", pal_sel_o, 0);
      vs_pulse(1'b1);
      check("wrapA_frame", frame_o, 0);
      check("wrapA_pal", pal_sel_o, AUTO_INC);
      check("wrapA_intro", intro_done_o, 1);
      exp_pal = AUTO_INC;

      // RUN wrap with a palette press landing on the same edge.
      while (model_frame != 10'd1021) vs_pulse(1'b1);
      pal_btn = 1'b1;
      vs_pulse(1'b1); vs_pulse(1'b1);
      check("wrapB_pre", pal_sel_o, exp_pal);
      vs_pulse(1'b1);
      exp_pal = exp_pal + 2'd1 + AUTO_INC;
      check("wrapB_frame", frame_o, 0);
      check("wrapB_pal", pal_sel_o, exp_pal);
      pal_btn = 1'b0;
      for (int i = 0; i < 3; i++) vs_pulse(1'b1);
      check("wrapB_hold", pal_sel_o, exp_pal);

      // Asynchronous reset mid-frame, intro restarts.
      @(negedge clk);
      vsync_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_frame", frame_o, 0);
      check("mrst_intro", intro_done_o, 0);
      check("mrst_pal", pal_sel_o, 0);
      check("mrst_paused", paused_o, 0);
      check("sb_pre_rst", exp_q.size(), 0);
      exp_q.delete();
      model_frame = '0;
      @(negedge clk);
      vsync_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      vs_pulse(1'b1);
      check("mrst_replay", frame_o, 1);
      check("mrst_intro2", intro_done_o, 0);

      repeat (3) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
